carry_select_subtractor8_pipe: RTL and testbench
================================================

# carry_select_subtractor8_pipe

Two-stage pipelined 8-bit carry-select subtractor with borrow-in/borrow-out and valid/ready flow control on both sides. Stage 1 computes the low-nibble difference and its borrow, plus both speculative high-nibble differences (borrow 0 and borrow 1). Stage 2 selects the high nibble with the resolved low-nibble borrow. It is the subtract-side counterpart to the 8-bit carry-select adder, for datapaths that need registered throughput of one operation per cycle.

## Interface
Parameters:
- none. Width is fixed at 8 bits, split into two 4-bit nibbles.

Ports:
- `clk`  in  1  Sole clock. All state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `in_valid`  in  1  Operands on `a`, `b`, `bin` are valid.
- `in_ready`  out  1  Stage 1 can accept operands this cycle.
- `a`  in  8  Minuend.
- `b`  in  8  Subtrahend.
- `bin`  in  1  Borrow-in.
- `out_valid`  out  1  `diff` and `bout` hold a result.
- `out_ready`  in  1  Downstream accepts the result this cycle.
- `diff`  out  8  (a − b − bin) mod 256. Registered.
- `bout`  out  1  Borrow-out: 1 iff a < b + bin, unsigned. Registered.

## Operation
- Arithmetic: the 9-bit result {bout, diff} = {1'b0,a} − {1'b0,b} − bin, two's complement; `bout` is the inverted carry-out of a + ~b + ~bin.
- Stage 1 (register s1), on an input transfer (`in_valid && in_ready`):
  - lo = a[3:0] − b[3:0] − bin → s1_lo[3:0] and s1_blo (low-nibble borrow).
  - hi0 = a[7:4] − b[7:4] → s1_hi0[3:0] and s1_b0.
  - hi1 = a[7:4] − b[7:4] − 1 → s1_hi1[3:0] and s1_b1.
  - s1_valid ← 1.
- Stage 2 (output register), on a stage advance:
  - diff ← {s1_blo ? s1_hi1 : s1_hi0, s1_lo}.
  - bout ← s1_blo ? s1_b1 : s1_b0.
  - out_valid ← 1.
- Flow control. The pipeline is stallable with no skid buffer:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready (combinational).
  - Stage advance occurs when s1_valid && s2_ready.
- Valid bookkeeping:
  - s1_valid clears when s1 advances and no new input is accepted in the same cycle.
  - out_valid clears when out_ready is high and no advance occurs in the same cycle.
- Both stages may transfer in the same cycle: s1 advances into the output register while new operands load into s1.
- Data registers load only on their transfer. Payload registers do not change at any other time.

## Timing
- Reset (rst high at an edge): s1_valid=0, out_valid=0, diff=8'h00, bout=0, all s1 payload registers cleared to 0.
  - in_ready is 1 in the cycle after reset.
  - Reset takes priority over any simultaneous transfer. In-flight data is discarded with no partial output.
- Latency: operands accepted at edge N appear on diff/bout with out_valid=1 after edge N+1, assuming no stall.
- Throughput: one result per cycle while out_ready stays high.
- Stall: while out_valid=1 and out_ready=0, diff/bout/out_valid hold stable.
  - s1 fills and holds; in_ready drops to 0 once s1_valid=1.
  - When out_ready rises, the output and s1 both advance in that cycle, and in_ready returns to 1 combinationally.
- in_valid with in_ready=0: the operands are not captured. The source must hold them.
- Wrap-around: diff wraps modulo 256 with no saturation. Nibble borrow selection must be exact at 0x_0 − 0x_1 boundaries.
- Both paths are fully registered; only in_ready is combinational from out_ready.

## Test plan
- Basic: a=0x35, b=0x12, bin=0 → diff=0x23, bout=0, out_valid exactly 2 edges after acceptance.
- Underflow: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1.
- Cross-nibble borrow select: a=0x10, b=0x00, bin=1 → diff=0x0F, bout=0. Then a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0.
- Back-to-back with backpressure: stream 4 operand sets with out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready drops after s1 fills, diff/bout are held stable during the stall, and all 4 results are delivered in order with none lost or duplicated.
- Reset mid-operation: assert rst with s1 and the output both valid.
  - Required next cycle: out_valid=0, diff=0x00, bout=0, in_ready=1. No stale result appears afterwards.
- Random: 10k random a/b/bin with random in_valid/out_ready. Compare against the scoreboard {bout,diff} = a − b − bin (9-bit).

Source files
------------

// File: rtl/carry_select_subtractor8_pipe.sv
// Two-stage pipelined 8-bit carry-select subtractor with valid/ready on both sides.
// Stage 1 resolves the low nibble and both speculative high nibbles; stage 2 selects.
module carry_select_subtractor8_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] diff,
  output logic       bout
);

  // Returns {borrow, difference} of x - y - bi; bit 4 is set exactly when the result is negative.
  function automatic logic [4:0] nib_sub(input logic [3:0] x, input logic [3:0] y,
                                         input logic bi);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'b0000, bi};
    return t;
  endfunction

  logic [3:0] lo_p1, hi0_p1, hi1_p1;
  logic       blo_p1, b0_p1, b1_p1;
  logic       vld_p1;
  logic       s2_ready, acc, adv;
  logic [4:0] lo_n, hi0_n, hi1_n;

  assign lo_n  = nib_sub(a[3:0], b[3:0], bin);
  assign hi0_n = nib_sub(a[7:4], b[7:4], 1'b0);
  assign hi1_n = nib_sub(a[7:4], b[7:4], 1'b1);

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_ready;
  assign acc      = in_valid && in_ready;
  assign adv      = vld_p1 && s2_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (acc)      vld_p1 <= 1'b1;
      else if (adv) vld_p1 <= 1'b0;
      if (adv)            out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  // p0 -> p1: low nibble plus both speculative high nibbles
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_p1  <= 4'h0;
      blo_p1 <= 1'b0;
      hi0_p1 <= 4'h0;
      b0_p1  <= 1'b0;
      hi1_p1 <= 4'h0;
      b1_p1  <= 1'b0;
    end else if (acc) begin
      lo_p1  <= lo_n[3:0];
      blo_p1 <= lo_n[4];
      hi0_p1 <= hi0_n[3:0];
      b0_p1  <= hi0_n[4];
      hi1_p1 <= hi1_n[3:0];
      b1_p1  <= hi1_n[4];
    end
  end

  // p1 -> p2: resolved low-nibble borrow picks the high nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= 8'h00;
      bout <= 1'b0;
    end else if (adv) begin
      diff <= {blo_p1 ? hi1_p1 : hi0_p1, lo_p1};
      bout <= blo_p1 ? b1_p1 : b0_p1;
    end
  end

endmodule

// File: tb/tb_carry_select_subtractor8_pipe.sv
// Scoreboard bench for carry_select_subtractor8_pipe: expected {bout,diff} queued on
// acceptance, popped and compared whenever a result transfers out.
module tb_carry_select_subtractor8_pipe;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [7:0] a, b, diff;
  logic [8:0] exp_cur;
  logic [8:0] sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         pops = 0;

  always #5 clk = ~clk;

  carry_select_subtractor8_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Record the expected result of each accepted operand set.
  always @(negedge clk) begin
    if (rst) sbq.delete();
    else if (in_valid && in_ready) sbq.push_back(exp_cur);
  end

  // Compare every result that leaves the DUT against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got %0h want none", {bout, diff});
      end else begin
        chk("result", {23'd0, bout, diff}, {23'd0, sbq.pop_front()});
        pops++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic xbin,
                      input logic [8:0] e);
    logic acc, done;
    a = xa; b = xb; bin = xbin; exp_cur = e; in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      acc = in_ready;
      step;
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got not_accepted want accepted");
    end
  endtask

  task automatic drain;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sbq.size() != 0; i++) step;
    step;
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    int         sent, cyc, p0;
    logic       pend, acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; bin = 1'b0; exp_cur = 9'h000;
    step; step;
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bout", bout, 0);
    chk("reset_in_ready", in_ready, 1);

    // Basic vector and latency
    a = 8'h35; b = 8'h12; bin = 1'b0; exp_cur = 9'h023; in_valid = 1'b1;
    chk("basic_in_ready", in_ready, 1);
    step;
    in_valid = 1'b0;
    chk("latency_edge1_valid", out_valid, 0);
    step;
    chk("latency_edge2_valid", out_valid, 1);
    chk("basic_value", {bout, diff}, 9'h023);
    step;

    // Underflow and nibble-boundary borrow selection
    send(8'h00, 8'h01, 1'b0, 9'h1FF);
    send(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    send(8'h10, 8'h00, 1'b1, 9'h00F);
    send(8'h80, 8'h01, 1'b0, 9'h07F);
    drain;

    // Back-to-back stream with a 3-cycle output stall
    p0 = pops;
    send(8'h9C, 8'h47, 1'b0, 9'h055);
    send(8'h20, 8'h31, 1'b1, 9'h1EE);
    out_ready = 1'b0;
    a = 8'hF0; b = 8'h0F; bin = 1'b0; exp_cur = 9'h0E1; in_valid = 1'b1;
    #1;
    chk("stall_in_ready_low", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_hold", {bout, diff}, 9'h055);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    send(8'hF0, 8'h0F, 1'b0, 9'h0E1);
    send(8'h01, 8'h02, 1'b1, 9'h1FE);
    drain;
    chk("stream_count", pops - p0, 4);

    // Reset with both stages holding data
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 9'h1DE);
    send(8'h55, 8'hAA, 1'b0, 9'h1AB);
    chk("preset_out_valid", out_valid, 1);
    a = 8'h77; b = 8'h11; bin = 1'b0; exp_cur = 9'h066; in_valid = 1'b1;
    rst = 1'b1;
    step;
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("midrst_no_stale", out_valid, 0);
    end

    // Random traffic with random backpressure
    sent = 0; cyc = 0; pend = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom_range(0, 1));
        exp_cur = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        pend = 1'b1;
      end
      in_valid = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      step;
      if (acc) begin
        pend = 1'b0;
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("random_sent", sent, 10000);
    drain;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
